// File: rtl/div_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : div_request_sequencer
// Brief    : Request FIFO and start/end handshake sequencer for the fixed-point
//            divider. It holds each quotient in a valid/ready response register.
//            The optional DIV_ZERO_BYPASS_EN feature answers zero divisors locally.
// Revision : 1.0 - initial release
// ============================================================================
module div_request_sequencer #(
    parameter int INTEGER_SIZE = 16,
    parameter int FRACT_SIZE   = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int TAG_WIDTH    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [INTEGER_SIZE+FRACT_SIZE-1:0]   req_dividend,
    input  logic [INTEGER_SIZE+FRACT_SIZE-1:0]   req_divisor,
    input  logic [TAG_WIDTH-1:0]                 req_tag,
    output logic                                 div_start,
    output logic [INTEGER_SIZE+FRACT_SIZE-1:0]   div_dividend,
    output logic [INTEGER_SIZE+FRACT_SIZE-1:0]   div_divisor,
    input  logic                                 div_end,
    input  logic [INTEGER_SIZE+FRACT_SIZE-1:0]   div_quotient,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [INTEGER_SIZE+FRACT_SIZE-1:0]   rsp_quotient,
    output logic [TAG_WIDTH-1:0]                 rsp_tag,
    output logic                                 rsp_div_zero,
    output logic                                 busy,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_level
);

    localparam int c_W     = INTEGER_SIZE + FRACT_SIZE;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;

    logic [c_W-1:0]       r_mem_dvd [FIFO_DEPTH];
    logic [c_W-1:0]       r_mem_dvs [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0] r_mem_tag [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_count;
    logic [c_LVL_W-1:0]   w_count_next;
    logic                 r_req_ready;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_issue;
    logic                 w_bypass;
    logic                 w_head_ok;
    logic                 w_head_zero;
    logic                 w_rsp_free;
    logic                 w_div_done;
    logic                 w_rsp_load;
    logic                 w_div_start;

    logic [c_W-1:0]       r_div_dvd;
    logic [c_W-1:0]       r_div_dvs;
    logic [TAG_WIDTH-1:0] r_cur_tag;

    logic                 r_rsp_valid;
    logic [c_W-1:0]       r_rsp_q;
    logic [TAG_WIDTH-1:0] r_rsp_tag;
    logic                 r_rsp_dz;
    logic [c_W-1:0]       w_rsp_q_in;
    logic [TAG_WIDTH-1:0] w_rsp_tag_in;
    logic                 w_rsp_dz_in;

    assign w_push     = req_valid && r_req_ready;
    assign w_pop      = w_issue || w_bypass;
    // The response slot counts as free when it is being drained this very edge.
    assign w_rsp_free = !r_rsp_valid || rsp_ready;
    assign w_head_ok  = (r_count != '0) && w_rsp_free;
    assign w_div_done = (r_state == c_ST_WAIT) && div_end;
    assign w_rsp_load = w_div_done || w_bypass;

`ifdef DIV_ZERO_BYPASS_EN
    logic [c_W-1:0] w_head_dvd;
    logic [c_W-1:0] w_sat_q;

    assign w_head_dvd  = r_mem_dvd[r_rd_ptr];
    assign w_head_zero = (r_mem_dvs[r_rd_ptr] == '0);

    always_comb begin
        w_sat_q = {1'b0, {(c_W-1){1'b1}}};
        if (w_head_dvd[c_W-1]) begin
            w_sat_q = {1'b1, {(c_W-1){1'b0}}};
        end else if (w_head_dvd == '0) begin
            w_sat_q = '0;
        end
    end

    assign w_rsp_q_in  = w_bypass ? w_sat_q : div_quotient;
    assign w_rsp_dz_in = w_bypass;
`else
    assign w_head_zero = 1'b0;
    assign w_rsp_q_in  = div_quotient;
    assign w_rsp_dz_in = 1'b0;
`endif

    assign w_rsp_tag_in = w_bypass ? r_mem_tag[r_rd_ptr] : r_cur_tag;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_head_ok && !w_head_zero) begin
                    w_state_next = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: w_state_next = c_ST_WAIT;
            c_ST_WAIT: begin
                if (div_end) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_div_start = 1'b0;
        w_issue     = 1'b0;
        w_bypass    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_head_ok) begin
                    w_bypass = w_head_zero;
                    w_issue  = !w_head_zero;
                end
            end
            c_ST_ISSUE: w_div_start = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_LVL_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_LVL_W'(1);
        end
    end

    // Storage is left unreset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_dvd[r_wr_ptr] <= req_dividend;
            r_mem_dvs[r_wr_ptr] <= req_divisor;
            r_mem_tag[r_wr_ptr] <= req_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_req_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count     <= w_count_next;
            r_req_ready <= (w_count_next != c_LVL_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_dvd <= '0;
            r_div_dvs <= '0;
            r_cur_tag <= '0;
        end else if (w_issue) begin
            r_div_dvd <= r_mem_dvd[r_rd_ptr];
            r_div_dvs <= r_mem_dvs[r_rd_ptr];
            r_cur_tag <= r_mem_tag[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_q     <= '0;
            r_rsp_tag   <= '0;
            r_rsp_dz    <= 1'b0;
        end else if (w_rsp_load) begin
            r_rsp_valid <= 1'b1;
            r_rsp_q     <= w_rsp_q_in;
            r_rsp_tag   <= w_rsp_tag_in;
            r_rsp_dz    <= w_rsp_dz_in;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_q     <= '0;
            r_rsp_tag   <= '0;
            r_rsp_dz    <= 1'b0;
        end
    end

    assign req_ready    = r_req_ready;
    assign div_start    = w_div_start;
    assign div_dividend = r_div_dvd;
    assign div_divisor  = r_div_dvs;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_quotient = r_rsp_q;
    assign rsp_tag      = r_rsp_tag;
    assign rsp_div_zero = r_rsp_dz;
    assign fifo_level   = r_count;
    assign busy         = (r_state != c_ST_IDLE) || (r_count != '0) || r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_div_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_request_sequencer
// Brief    : Directed self-checking bench with a 48-iteration divider stand-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_request_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_dividend;
    logic [W-1:0]  req_divisor;
    logic [3:0]    req_tag;
    logic          div_start;
    logic [W-1:0]  div_dividend;
    logic [W-1:0]  div_divisor;
    logic          div_end;
    logic [W-1:0]  div_quotient;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_quotient;
    logic [3:0]    rsp_tag;
    logic          rsp_div_zero;
    logic          busy;
    logic [2:0]    fifo_level;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_starts = 0;

    div_request_sequencer #(
        .INTEGER_SIZE (16),
        .FRACT_SIZE   (16),
        .FIFO_DEPTH   (4),
        .TAG_WIDTH    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_tag      (req_tag),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_end      (div_end),
        .div_quotient (div_quotient),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_quotient (rsp_quotient),
        .rsp_tag      (rsp_tag),
        .rsp_div_zero (rsp_div_zero),
        .busy         (busy),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (div_start) n_starts <= n_starts + 1;

    // Divider stand-in: end_div pulses 48 cycles after start_div is sampled.
    function automatic logic [W-1:0] fx_div(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] n;
        logic signed [63:0] d;
        logic signed [63:0] q;
        n = $signed({{32{a[31]}}, a}) <<< 16;
        d = $signed({{32{b[31]}}, b});
        if (d == 0) return '0;
        q = n / d;
        return q[W-1:0];
    endfunction

    logic [7:0]   m_cnt;
    logic [W-1:0] m_q;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 8'd0;
            m_q   <= '0;
        end else if (div_start) begin
            m_cnt <= 8'd49;
            m_q   <= fx_div(div_dividend, div_divisor);
        end else if (m_cnt != 8'd0) begin
            m_cnt <= m_cnt - 8'd1;
        end
    end
    assign div_end      = (m_cnt == 8'd1);
    assign div_quotient = div_end ? m_q : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] t, output int at);
        req_dividend = a;
        req_divisor  = b;
        req_tag      = t;
        req_valid    = 1'b1;
        at = -1;
        for (int i = 0; i < 300; i++) begin
            if (req_ready) begin
                @(negedge clk);
                at = cyc;
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (at < 0) check("req_timeout", 0, 1);
    endtask

    task automatic wait_rsp(output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("rsp_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int a0, r0, base, stable;
        int acc[6];
        int rc[6];
        logic [W-1:0] hq;
        logic [3:0]   ht;

        rst = 1'b1; req_valid = 1'b0; req_dividend = '0; req_divisor = '0;
        req_tag = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {req_ready, div_start, rsp_valid, busy, fifo_level, rsp_quotient},
              64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_ready", {req_ready, busy, fifo_level}, {1'b1, 1'b0, 3'd0});

        // 6.0 / 2.0, tag 3
        base = n_starts;
        send(32'h0006_0000, 32'h0002_0000, 4'd3, a0);
        wait_rsp(r0);
        check("q_6_2",      rsp_quotient, 32'h0003_0000);
        check("tag_6_2",    rsp_tag, 4'd3);
        check("dz_6_2",     rsp_div_zero, 1'b0);
        check("lat_6_2",    r0 - a0, 51);
        check("starts_6_2", n_starts - base, 1);

        @(negedge clk);
        send(32'hFFF8_8000, 32'h0002_8000, 4'd5, a0);
        wait_rsp(r0);
        check("q_m7p5_2p5", rsp_quotient, 32'hFFFD_0000);
        check("tag_m7p5",   rsp_tag, 4'd5);

        @(negedge clk);
        send(32'h0001_0000, 32'hFFFC_0000, 4'd9, a0);
        wait_rsp(r0);
        check("q_1_m4",     rsp_quotient, 32'hFFFF_C000);

        // Six back-to-back requests
        @(negedge clk);
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    send(32'((k + 1) << 16), 32'h0001_0000, 4'(k), acc[k]);
                    if (k == 4) begin
                        check("b2b_level_full", fifo_level, 3'd4);
                        check("b2b_ready_low",  req_ready, 1'b0);
                    end
                end
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    wait_rsp(rc[k]);
                    check("b2b_tag", rsp_tag, 4'(k));
                    check("b2b_q",   rsp_quotient, 32'((k + 1) << 16));
                end
            end
        join
        check("b2b_first_lat",  rc[0] - acc[0], 51);
        check("b2b_stall_6th",  acc[5] - acc[0], 53);
        check("b2b_throughput", rc[1] - rc[0], 51);

        // Response held off by rsp_ready
        @(negedge clk);
        rsp_ready = 1'b0;
        send(32'h0002_0000, 32'h0001_0000, 4'd1, a0);
        send(32'h0005_0000, 32'h0001_0000, 4'd2, a0);
        wait_rsp(r0);
        hq = rsp_quotient; ht = rsp_tag;
        check("hold_q",   hq, 32'h0002_0000);
        base = n_starts; stable = 1;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_quotient !== hq || rsp_tag !== ht || div_start !== 1'b0)
                stable = 0;
        end
        check("hold_stable",   stable, 1);
        check("hold_no_start", n_starts - base, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hs_cleared",    rsp_valid, 1'b0);
        check("hs_next_issue", div_start, 1'b1);
        wait_rsp(r0);
        check("hold_2nd_tag",  rsp_tag, 4'd2);
        check("hold_2nd_q",    rsp_quotient, 32'h0005_0000);

`ifdef DIV_ZERO_BYPASS_EN
        @(negedge clk);
        base = n_starts;
        send(32'h0005_0000, 32'h0000_0000, 4'd7, a0);
        wait_rsp(r0);
        check("bz_pos_q",   rsp_quotient, 32'h7FFF_FFFF);
        check("bz_pos_dz",  rsp_div_zero, 1'b1);
        check("bz_pos_tag", rsp_tag, 4'd7);
        check("bz_pos_lat", r0 - a0, 1);
        @(negedge clk);
        send(32'hFFFB_0000, 32'h0000_0000, 4'd8, a0);
        wait_rsp(r0);
        check("bz_neg_q",   rsp_quotient, 32'h8000_0000);
        @(negedge clk);
        send(32'h0000_0000, 32'h0000_0000, 4'd6, a0);
        wait_rsp(r0);
        check("bz_zero_q",  rsp_quotient, 32'h0000_0000);
        check("bz_zero_dz", rsp_div_zero, 1'b1);
        check("bz_starts",  n_starts - base, 0);
`else
        @(negedge clk);
        base = n_starts;
        send(32'h0005_0000, 32'h0000_0000, 4'd7, a0);
        wait_rsp(r0);
        check("z_dz_tied",  rsp_div_zero, 1'b0);
        check("z_issued",   n_starts - base, 1);
        check("z_q_passed", rsp_quotient, 32'h0000_0000);
`endif

        // Reset mid-WAIT with three entries queued
        @(negedge clk);
        for (int k = 0; k < 4; k++) send(32'h0001_0000, 32'h0001_0000, 4'(k), a0);
        repeat (10) @(negedge clk);
        check("pre_rst_level", fifo_level, 3'd3);
        rst = 1'b1;
        #1;
        check("rst_outputs", {req_ready, div_start, rsp_valid, busy, fifo_level, div_dividend},
              64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst", {req_ready, busy, rsp_valid, fifo_level}, {1'b1, 1'b0, 1'b0, 3'd0});
        send(32'h0009_0000, 32'h0003_0000, 4'd4, a0);
        wait_rsp(r0);
        check("after_rst_q",   rsp_quotient, 32'h0003_0000);
        check("after_rst_tag", rsp_tag, 4'd4);
        check("after_rst_lat", r0 - a0, 51);

        repeat (3) @(negedge clk);
        check("final_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_request_sequencer.md
# div_request_sequencer

Front-end/back-end wrapper for the non-restoring fixed-point divider. It queues signed operand pairs in a small request FIFO and issues them one at a time over the divider's start_div/end_div handshake. It then captures the one-cycle quotient pulse into a held response register with valid/ready and tag. It sits between the datapath producer and the `binary_division` instance; the two blocks are instantiated side by side.

## Interface
- INTEGER_SIZE, 16, integer bits of operands/quotient (must match divider)
- FRACT_SIZE, 16, fraction bits (must match divider); W = INTEGER_SIZE+FRACT_SIZE
- FIFO_DEPTH, 4, request FIFO entries, power of two, ≥2
- TAG_WIDTH, 4, opaque request tag width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  FIFO not full
- req_dividend  in  W  signed Q(INTEGER_SIZE.FRACT_SIZE)
- req_divisor  in  W  signed Q format
- req_tag  in  TAG_WIDTH  returned with result
- div_start  out  1  to divider start_div; one-cycle pulse
- div_dividend  out  W  to divider dividend; held from issue until next issue
- div_divisor  out  W  to divider divisor; held likewise
- div_end  in  1  from divider end_div
- div_quotient  in  W  from divider Q_output; valid only while div_end=1
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts
- rsp_quotient  out  W  signed quotient
- rsp_tag  out  TAG_WIDTH  tag of this result
- rsp_div_zero  out  1  divisor was zero (see Configuration)
- busy  out  1  FSM not IDLE, or FIFO non-empty, or rsp_valid
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries

## Operation
- FIFO: push on req_valid&&req_ready; pop only on issue. req_ready = (level≠FIFO_DEPTH) from registered count. No push when full, even if a pop occurs that cycle. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE → ISSUE when FIFO non-empty and rsp_valid=0:
  - pops head;
  - registers div_dividend/div_divisor/tag;
  - div_start=1 for the ISSUE cycle only.
- ISSUE → WAIT unconditionally; div_start returns to 0.
- WAIT → IDLE on div_end=1:
  - div_quotient and the held tag are written into the response register;
  - rsp_valid←1 next cycle.
- div_end outside WAIT is ignored.
- At most one division is outstanding; a new issue requires an empty response register, so no quotient pulse is ever lost.
- Response: rsp_* stable while rsp_valid && !rsp_ready; cleared on the handshake. The earliest next issue is the cycle after the handshake.
- Results are returned in request order.
- Reset (any state, including mid-WAIT):
  - FIFO empties, FSM goes to IDLE;
  - all outputs become 0 (req_ready=1 after reset deasserts);
  - the divider's own reset must be asserted in the same window.

## Timing
- Request accepted at edge E into an empty FIFO with an idle sequencer: div_start is high in cycle E+1→E+2.
- div_end sampled at edge T: rsp_valid=1 from T onward (registered).
- With the divider's NO_ITERATIONS = INTEGER_SIZE+2·FRACT_SIZE = 48 (defaults), accept-to-rsp_valid is 51 cycles. This latency is not hard-coded; completion is always taken from div_end.
- Throughput: one result per (divider latency + 3) cycles with rsp_ready held high.

## Configuration
- DIV_ZERO_BYPASS_EN defined:
  - In IDLE, a head entry with divisor==0 is popped without issuing.
  - The response is written directly the next cycle with rsp_div_zero=1.
  - Quotient: 0x7FFF…F if dividend>0, 0x800…0 if dividend<0, 0 if dividend==0.
  - No div_start is generated for that entry.
- Undefined: rsp_div_zero is tied 0. Zero divisors are issued normally and the divider's output is returned unmodified.

## Test plan
- 6.0/2.0 (0x00060000/0x00020000), tag 3 → rsp_quotient 0x00030000, rsp_tag 3, exactly one div_start pulse, rsp_valid 51 cycles after accept.
- −7.5/2.5 (0xFFF88000/0x00028000) → 0xFFFD0000; 1.0/−4.0 → 0xFFFFC000.
- Six back-to-back requests, tags 0–5, with rsp_ready=1:
  - first request issues immediately, the next four fill the FIFO;
  - req_ready drops; the sixth request stalls until the first issue pop;
  - responses arrive in tag order 0–5.
- rsp_ready held low 20 cycles after a result → rsp_* stable, no div_start; next issue occurs the cycle after the handshake.
- With DIV_ZERO_BYPASS_EN:
  - 5.0/0 → 0x7FFFFFFF with div_zero=1 and no div_start;
  - −5.0/0 → 0x80000000;
  - 0/0 → 0.
- rst pulsed during WAIT with 3 entries queued → all outputs 0, fifo_level 0. A following 9.0/3.0 request returns 0x00030000 normally.
